pwm_duty_ramp: RTL and testbench

Slew-rate limiter placed directly upstream of the PWM generator. It accepts a target duty cycle and moves its registered 7-bit duty output toward that target by a fixed step on PWM period boundaries. The PWM generator therefore never sees an abrupt duty jump and never sees a mid-period change. Typical uses are soft-start and fade of loads driven by the PWM outputs.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_ramp_prescaler.sv | 22 ++
 rtl/pwm_duty_ramp.sv | 91 +++++++++
 tb/tb_pwm_duty_ramp.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-ramp block.
package pwm_pkg;
  localparam int DC_W   = 7;
  localparam int DC_MAX = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

  typedef logic [DC_W-1:0] duty_t;
endpackage

// File: rtl/pwm_ramp_prescaler.sv
// Divides PWM period ticks by 2^rate and emits a one-cycle step pulse.
module pwm_ramp_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       tick,
  input  logic [1:0] rate,
  output logic       step
);
  logic [2:0] cnt;
  logic [2:0] term;

  // 2^rate - 1; rate=3 wraps to 7, which is exactly what is wanted
  assign term = 3'((4'd1 << rate) - 4'd1);
  assign step = tick & ~clr & (cnt == term);

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= step ? 3'd0 : cnt + 3'd1;
  end
endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter: steps the registered duty toward a clamped target on period ticks.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int DC_W   = pwm_pkg::DC_W,
  parameter int DC_MAX = pwm_pkg::DC_MAX,
  parameter int STEP   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DC_W-1:0] target,
  input  logic            load,
  input  logic [1:0]      rate_sel,
  input  logic            period_tick,
  output logic [DC_W-1:0] dc,
  output logic            busy,
  output logic            at_target,
  output logic            dir
);
  localparam logic [DC_W-1:0] MAX_D  = DC_W'(DC_MAX);
  localparam logic [DC_W:0]   STEP_W = (DC_W+1)'(STEP);

  ramp_state_t     state, state_nxt;
  logic [DC_W-1:0] tgt_q, tgt_nxt, dc_nxt, tgt_clamp, step_dc;
  logic [1:0]      rate_q, rate_nxt;
  logic            step, pre_clr;

  logic [DC_W:0]          sum;
  logic signed [DC_W+1:0] diff;

  // Prescaler is held clear while idle and restarts on every load
  assign pre_clr = load | (state == IDLE);

  pwm_ramp_prescaler u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .tick  (period_tick),
    .rate  (rate_q),
    .step  (step)
  );

  assign tgt_clamp = (target > MAX_D) ? MAX_D : target;

  // Widened so that neither direction can wrap before clamping to the target
  assign sum  = {1'b0, dc} + STEP_W;
  assign diff = $signed({2'b00, dc}) - $signed({1'b0, STEP_W});

  always_comb begin
    step_dc = dc;
    if (state == UP)
      step_dc = (sum > {1'b0, tgt_q}) ? tgt_q : sum[DC_W-1:0];
    else if (state == DOWN)
      step_dc = (diff < $signed({2'b00, tgt_q})) ? tgt_q : diff[DC_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    dc_nxt    = dc;
    tgt_nxt   = tgt_q;
    rate_nxt  = rate_q;
    if (load) begin
      tgt_nxt  = tgt_clamp;
      rate_nxt = rate_sel;
      if (tgt_clamp > dc)      state_nxt = UP;
      else if (tgt_clamp < dc) state_nxt = DOWN;
      else                     state_nxt = IDLE;
    end else if (step && state != IDLE) begin
      dc_nxt = step_dc;
      if (step_dc == tgt_q) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      dc     <= '0;
      tgt_q  <= '0;
      rate_q <= '0;
    end else begin
      state  <= state_nxt;
      dc     <= dc_nxt;
      tgt_q  <= tgt_nxt;
      rate_q <= rate_nxt;
    end
  end

  assign at_target = (dc == tgt_q);
  assign busy      = (state != IDLE);
  assign dir       = (state == UP);
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed checks of pwm_duty_ramp with STEP=1 and STEP=7 instances.
module tb_pwm_duty_ramp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] target = '0, target7 = '0;
  logic       load = 1'b0, load7 = 1'b0;
  logic [1:0] rate_sel = '0, rate_sel7 = '0;
  logic       period_tick = 1'b0, period_tick7 = 1'b0;
  logic [6:0] dc, dc7;
  logic       busy, at_target, dir, busy7, at_target7, dir7;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(.STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .target(target), .load(load), .rate_sel(rate_sel),
    .period_tick(period_tick), .dc(dc), .busy(busy), .at_target(at_target), .dir(dir)
  );

  pwm_duty_ramp #(.STEP(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .target(target7), .load(load7), .rate_sel(rate_sel7),
    .period_tick(period_tick7), .dc(dc7), .busy(busy7), .at_target(at_target7), .dir(dir7)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one period tick followed by seven quiet clocks
  task automatic tick();
    period_tick = 1'b1;
    cyc();
    period_tick = 1'b0;
    repeat (7) cyc();
  endtask

  task automatic tick7();
    period_tick7 = 1'b1;
    cyc();
    period_tick7 = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic do_load(input logic [6:0] t, input logic [1:0] r, input logic with_tick);
    target = t; rate_sel = r; load = 1'b1; period_tick = with_tick;
    cyc();
    load = 1'b0; period_tick = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) cyc();
    chk("rst_dc", {1'b0, dc}, 8'd0);
    chk("rst_at_target", {7'd0, at_target}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_dir", {7'd0, dir}, 8'd0);
    rst_n = 1'b1;
    cyc();

    // idle ignores ticks
    repeat (20) tick();
    chk("idle_dc", {1'b0, dc}, 8'd0);
    chk("idle_busy", {7'd0, busy}, 8'd0);

    // ramp 0 -> 10 at rate 0
    do_load(7'd10, 2'd0, 1'b0);
    chk("up_busy", {7'd0, busy}, 8'd1);
    chk("up_dir", {7'd0, dir}, 8'd1);
    chk("up_at_target", {7'd0, at_target}, 8'd0);
    chk("up_dc0", {1'b0, dc}, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("up_dc", {1'b0, dc}, 8'(k));
    end
    chk("up_done_busy", {7'd0, busy}, 8'd0);
    chk("up_done_at", {7'd0, at_target}, 8'd1);

    // clamp: target 120 behaves as 100
    do_load(7'd120, 2'd0, 1'b0);
    for (int k = 11; k <= 100; k++) tick();
    chk("clamp_dc", {1'b0, dc}, 8'd100);
    chk("clamp_busy", {7'd0, busy}, 8'd0);
    chk("clamp_at", {7'd0, at_target}, 8'd1);
    repeat (5) tick();
    chk("clamp_hold", {1'b0, dc}, 8'd100);

    // down to 50, then retarget 80 -> 40 at rate 2
    do_load(7'd50, 2'd0, 1'b0);
    chk("down_dir", {7'd0, dir}, 8'd0);
    repeat (50) tick();
    chk("down_dc50", {1'b0, dc}, 8'd50);
    do_load(7'd80, 2'd0, 1'b0);
    chk("re_up_dir", {7'd0, dir}, 8'd1);
    do_load(7'd40, 2'd2, 1'b0);
    chk("re_dir", {7'd0, dir}, 8'd0);
    chk("re_busy", {7'd0, busy}, 8'd1);
    chk("re_dc", {1'b0, dc}, 8'd50);
    for (int s = 1; s <= 10; s++) begin
      repeat (3) tick();
      chk("re_hold", {1'b0, dc}, 8'(51 - s));
      tick();
      chk("re_step", {1'b0, dc}, 8'(50 - s));
    end
    chk("re_done_busy", {7'd0, busy}, 8'd0);

    // load beats a qualifying tick
    do_load(7'd44, 2'd0, 1'b0);
    do_load(7'd44, 2'd0, 1'b1);
    chk("lt_r0_dc", {1'b0, dc}, 8'd40);
    do_load(7'd50, 2'd1, 1'b0);
    tick();
    chk("lt_r1_first", {1'b0, dc}, 8'd40);
    do_load(7'd50, 2'd1, 1'b1);
    chk("lt_r1_nostep", {1'b0, dc}, 8'd40);
    tick();
    chk("lt_pre_cleared", {1'b0, dc}, 8'd40);
    tick();
    chk("lt_step", {1'b0, dc}, 8'd41);

    // reset mid-ramp at 33
    do_load(7'd0, 2'd0, 1'b0);
    repeat (8) tick();
    chk("mid_dc33", {1'b0, dc}, 8'd33);
    chk("mid_busy", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_dc", {1'b0, dc}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_at", {7'd0, at_target}, 8'd1);
    repeat (3) tick();
    chk("mid_rst_hold", {1'b0, dc}, 8'd0);

    // STEP=7: 0 -> 7 -> 10, then down to 2 via 3
    target7 = 7'd10; rate_sel7 = 2'd0; load7 = 1'b1;
    cyc();
    load7 = 1'b0;
    tick7();
    chk("s7_up1", {1'b0, dc7}, 8'd7);
    chk("s7_up1_busy", {7'd0, busy7}, 8'd1);
    tick7();
    chk("s7_up2", {1'b0, dc7}, 8'd10);
    chk("s7_up2_busy", {7'd0, busy7}, 8'd0);
    target7 = 7'd2; load7 = 1'b1;
    cyc();
    load7 = 1'b0;
    tick7();
    chk("s7_dn1", {1'b0, dc7}, 8'd3);
    tick7();
    chk("s7_dn2", {1'b0, dc7}, 8'd2);
    chk("s7_dn2_at", {7'd0, at_target7}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
